// File: rtl/commit_trace_buf.sv
// Commit-trace queue between writeback and the simulation harness: buffers retired
// instruction records, counts commits/drops and raises halt once prior commits drain.
module commit_trace_buf #(
  parameter int PC_WD      = 64,
  parameter int INST_WD    = 32,
  parameter int DATA_WD    = 64,
  parameter int ADDR_WD    = 5,
  parameter int DEPTH      = 8,
  parameter int HALT_DELAY = 4,
  parameter int OVF_STALL  = 1
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [PC_WD-1:0]           in_pc,
  input  logic [PC_WD-1:0]           in_dnpc,
  input  logic [INST_WD-1:0]         in_inst,
  input  logic                       in_rf_wen,
  input  logic [ADDR_WD-1:0]         in_rf_wnum,
  input  logic [DATA_WD-1:0]         in_rf_wdata,
  input  logic                       stop,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PC_WD-1:0]           out_pc,
  output logic [PC_WD-1:0]           out_dnpc,
  output logic [INST_WD-1:0]         out_inst,
  output logic                       out_rf_wen,
  output logic [ADDR_WD-1:0]         out_rf_wnum,
  output logic [DATA_WD-1:0]         out_rf_wdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic [63:0]                commit_cnt,
  output logic [31:0]                drop_cnt,
  output logic                       overflow,
  output logic                       halt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int RW = 2 * PC_WD + INST_WD + 1 + ADDR_WD + DATA_WD;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);

  logic [RW-1:0] mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [CW-1:0] count_r, count_nxt_s;
  logic          out_valid_r, in_ready_r;
  logic [63:0]   commit_cnt_r;
  logic [31:0]   drop_cnt_r;
  logic          overflow_r, halt_pend_r, halt_r;
  logic          full_s, push_s, pop_s, store_s, drop_s, stop_dly_s;

  // Handshake decode and next occupancy
  always_comb begin
    full_s      = (count_r == FULL_CNT);
    pop_s       = out_valid_r && out_ready;
    push_s      = in_valid && in_ready_r;
    store_s     = push_s && (!full_s || pop_s);
    drop_s      = push_s && !store_s;
    count_nxt_s = count_r;
    case ({store_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase
  end

  // Record storage; cleared so the head fields read zero out of reset
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= {RW{1'b0}};
    end else if (store_s) begin
      mem_r[wr_ptr_r] <= {in_pc, in_dnpc, in_inst, in_rf_wen, in_rf_wnum, in_rf_wdata};
    end
  end

  // Pointers, occupancy and the registered handshake flags derived from it
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_r    <= {AW{1'b0}};
      rd_ptr_r    <= {AW{1'b0}};
      count_r     <= {CW{1'b0}};
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
    end else begin
      if (store_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (pop_s)   rd_ptr_r <= rd_ptr_r + PTR_ONE;
      count_r     <= count_nxt_s;
      out_valid_r <= (count_nxt_s != {CW{1'b0}});
      // Drop mode keeps the producer unthrottled; stall mode blocks only at full
      in_ready_r  <= (OVF_STALL != 0) ? (count_nxt_s != FULL_CNT) : 1'b1;
    end
  end

  generate
    if (HALT_DELAY == 0) begin : g_no_dly
      assign stop_dly_s = stop;
    end else begin : g_dly
      logic [HALT_DELAY-1:0] dly_r;
      // Stop delay line aligning the trap with the retirement of older records
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          dly_r <= {HALT_DELAY{1'b0}};
        end else begin
          dly_r[0] <= stop;
          for (int i = 1; i < HALT_DELAY; i++) dly_r[i] <= dly_r[i-1];
        end
      end
      assign stop_dly_s = dly_r[HALT_DELAY-1];
    end
  endgenerate

  // Statistics and halt sequencing; halt waits for an empty queue with no new push
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      commit_cnt_r <= 64'd0;
      drop_cnt_r   <= 32'd0;
      overflow_r   <= 1'b0;
      halt_pend_r  <= 1'b0;
      halt_r       <= 1'b0;
    end else begin
      if (store_s) commit_cnt_r <= commit_cnt_r + 64'd1;
      if (drop_s && (drop_cnt_r != 32'hFFFF_FFFF)) drop_cnt_r <= drop_cnt_r + 32'd1;
      overflow_r  <= overflow_r | drop_s;
      halt_pend_r <= halt_pend_r | stop_dly_s;
      halt_r      <= halt_r | (halt_pend_r && (count_r == {CW{1'b0}}) && !push_s);
    end
  end

  assign {out_pc, out_dnpc, out_inst, out_rf_wen, out_rf_wnum, out_rf_wdata} = mem_r[rd_ptr_r];
  assign out_valid  = out_valid_r;
  assign in_ready   = in_ready_r;
  assign count      = count_r;
  assign commit_cnt = commit_cnt_r;
  assign drop_cnt   = drop_cnt_r;
  assign overflow   = overflow_r;
  assign halt       = halt_r;

endmodule

// File: tb/tb_commit_trace_buf.sv
// Scoreboard bench: a stall-mode and a drop-mode instance share one stimulus stream
// and are compared every cycle against a queue-based reference model.
module tb_commit_trace_buf;

  localparam int HD = 4;

  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] dnpc;
    logic [31:0] inst;
    logic        wen;
    logic [4:0]  wnum;
    logic [63:0] wdata;
  } rec_t;

  typedef struct packed {
    logic        ovalid;
    rec_t        head;
    logic [3:0]  count;
    logic        in_ready;
    logic [63:0] commit;
    logic [31:0] drop;
    logic        ovf;
    logic        halt;
  } obs_t;

  logic clk = 1'b0, resetn = 1'b0, in_valid = 1'b0, out_ready = 1'b0, stop = 1'b0;
  rec_t rec_in = '0;

  logic        st_in_ready, st_out_valid, st_wen, st_ovf, st_halt;
  logic [63:0] st_pc, st_dnpc, st_wdata, st_commit;
  logic [31:0] st_inst, st_drop;
  logic [4:0]  st_wnum;
  logic [3:0]  st_count;
  logic        dr_in_ready, dr_out_valid, dr_wen, dr_ovf, dr_halt;
  logic [63:0] dr_pc, dr_dnpc, dr_wdata, dr_commit;
  logic [31:0] dr_inst, dr_drop;
  logic [4:0]  dr_wnum;
  logic [3:0]  dr_count;

  int checks = 0;
  int failures = 0;

  rec_t        q0[$], q1[$];
  logic        sh[$];
  logic [63:0] m_commit[2];
  logic [31:0] m_drop[2];
  logic        m_ovf[2], m_pend[2], m_halt[2];

  always #5 clk = ~clk;

  commit_trace_buf #(.HALT_DELAY(HD), .OVF_STALL(1)) u_stall (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(st_in_ready),
    .in_pc(rec_in.pc), .in_dnpc(rec_in.dnpc), .in_inst(rec_in.inst),
    .in_rf_wen(rec_in.wen), .in_rf_wnum(rec_in.wnum), .in_rf_wdata(rec_in.wdata),
    .stop(stop), .out_valid(st_out_valid), .out_ready(out_ready),
    .out_pc(st_pc), .out_dnpc(st_dnpc), .out_inst(st_inst), .out_rf_wen(st_wen),
    .out_rf_wnum(st_wnum), .out_rf_wdata(st_wdata), .count(st_count),
    .commit_cnt(st_commit), .drop_cnt(st_drop), .overflow(st_ovf), .halt(st_halt)
  );

  commit_trace_buf #(.HALT_DELAY(HD), .OVF_STALL(0)) u_drop (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(dr_in_ready),
    .in_pc(rec_in.pc), .in_dnpc(rec_in.dnpc), .in_inst(rec_in.inst),
    .in_rf_wen(rec_in.wen), .in_rf_wnum(rec_in.wnum), .in_rf_wdata(rec_in.wdata),
    .stop(stop), .out_valid(dr_out_valid), .out_ready(out_ready),
    .out_pc(dr_pc), .out_dnpc(dr_dnpc), .out_inst(dr_inst), .out_rf_wen(dr_wen),
    .out_rf_wnum(dr_wnum), .out_rf_wdata(dr_wdata), .count(dr_count),
    .commit_cnt(dr_commit), .drop_cnt(dr_drop), .overflow(dr_ovf), .halt(dr_halt)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    q0.delete();
    q1.delete();
    sh.delete();
    for (int m = 0; m < 2; m++) begin
      m_commit[m] = 64'd0; m_drop[m] = 32'd0;
      m_ovf[m] = 1'b0; m_pend[m] = 1'b0; m_halt[m] = 1'b0;
    end
  endtask

  task automatic chk_reset(input string t, input obs_t o);
    chk({t, ".rst_count"}, o.count, 0);
    chk({t, ".rst_out_valid"}, o.ovalid, 0);
    chk({t, ".rst_in_ready"}, o.in_ready, 1);
    chk({t, ".rst_commit"}, o.commit, 0);
    chk({t, ".rst_drop"}, o.drop, 0);
    chk({t, ".rst_ovf"}, o.ovf, 0);
    chk({t, ".rst_halt"}, o.halt, 0);
    chk({t, ".rst_out_pc"}, o.head.pc, 0);
    chk({t, ".rst_out_wdata"}, o.head.wdata, 0);
  endtask

  // Compare one instance with the model, then advance the model across the coming edge
  task automatic step(input int m, input obs_t o, input logic dly);
    string t;
    int    sz;
    logic  rdy, mpop, push, store;
    rec_t  head;
    t   = (m == 0) ? "stall" : "drop";
    sz  = (m == 0) ? q0.size() : q1.size();
    rdy = (m == 0) ? (sz != 8) : 1'b1;
    chk({t, ".out_valid"}, o.ovalid, sz != 0);
    chk({t, ".count"}, o.count, sz);
    chk({t, ".in_ready"}, o.in_ready, rdy);
    chk({t, ".commit_cnt"}, o.commit, m_commit[m]);
    chk({t, ".drop_cnt"}, o.drop, m_drop[m]);
    chk({t, ".overflow"}, o.ovf, m_ovf[m]);
    chk({t, ".halt"}, o.halt, m_halt[m]);
    mpop = (sz != 0) && out_ready;
    if (mpop) begin
      if (m == 0) head = q0.pop_front();
      else        head = q1.pop_front();
      chk({t, ".out_pc"}, o.head.pc, head.pc);
      chk({t, ".out_dnpc"}, o.head.dnpc, head.dnpc);
      chk({t, ".out_inst"}, o.head.inst, head.inst);
      chk({t, ".out_wen_wnum"}, {o.head.wen, o.head.wnum}, {head.wen, head.wnum});
      chk({t, ".out_wdata"}, o.head.wdata, head.wdata);
    end
    push  = in_valid && rdy;
    store = push && (sz < 8 || mpop);
    m_halt[m] = m_halt[m] | (m_pend[m] && sz == 0 && !push);
    m_pend[m] = m_pend[m] | dly;
    if (store) begin
      if (m == 0) q0.push_back(rec_in);
      else        q1.push_back(rec_in);
      m_commit[m] = m_commit[m] + 64'd1;
    end else if (push) begin
      if (m_drop[m] != 32'hFFFF_FFFF) m_drop[m] = m_drop[m] + 32'd1;
      m_ovf[m] = 1'b1;
    end
  endtask

  // Monitor: samples on the falling edge, away from the DUT's active edge
  initial begin
    obs_t os, od;
    logic dly;
    model_clear();
    forever begin
      @(negedge clk);
      os = {st_out_valid, st_pc, st_dnpc, st_inst, st_wen, st_wnum, st_wdata,
            st_count, st_in_ready, st_commit, st_drop, st_ovf, st_halt};
      od = {dr_out_valid, dr_pc, dr_dnpc, dr_inst, dr_wen, dr_wnum, dr_wdata,
            dr_count, dr_in_ready, dr_commit, dr_drop, dr_ovf, dr_halt};
      if (!resetn) begin
        model_clear();
        chk_reset("stall", os);
        chk_reset("drop", od);
      end else begin
        sh.push_front(stop);
        dly = (sh.size() > HD) ? sh[HD] : 1'b0;
        while (sh.size() > HD + 1) void'(sh.pop_back());
        step(0, os, dly);
        step(1, od, dly);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0; in_valid = 1'b0; out_ready = 1'b0; stop = 1'b0;
    cyc();
    cyc();
    resetn = 1'b1;
  endtask

  task automatic drive(input logic v, input logic [63:0] pc);
    in_valid     = v;
    rec_in.pc    = pc;
    rec_in.dnpc  = pc + 64'd4;
    rec_in.inst  = $urandom;
    rec_in.wen   = 1'($urandom);
    rec_in.wnum  = 5'($urandom);
    rec_in.wdata = {$urandom, $urandom};
  endtask

  initial begin
    // Single record through an empty queue
    do_reset();
    rec_in = {64'h8000_0000, 64'h8000_0004, 32'h0010_0093, 1'b1, 5'd1, 64'd1};
    in_valid = 1'b1; out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    chk("p1.out_valid", st_out_valid, 1);
    chk("p1.out_pc", st_pc, 64'h8000_0000);
    chk("p1.count1", st_count, 1);
    cyc();
    chk("p1.count0", st_count, 0);
    chk("p1.commit", st_commit, 1);

    // Fill past capacity with the consumer stalled
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 64'h8000_0000 + 64'(4 * i));
      cyc();
      if (i == 7) begin
        chk("p2.stall_in_ready_full", st_in_ready, 0);
        chk("p2.stall_count_full", st_count, 8);
      end
    end
    chk("p2.stall_count", st_count, 8);
    chk("p2.stall_commit", st_commit, 8);
    chk("p2.drop_count", dr_count, 8);
    chk("p2.drop_cnt", dr_drop, 2);
    chk("p2.drop_ovf", dr_ovf, 1);
    chk("p2.drop_commit", dr_commit, 8);
    drive(1'b1, 64'h8000_0028);
    out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    chk("p2.full_pushpop_count", dr_count, 8);
    chk("p2.full_pushpop_commit", dr_commit, 9);
    chk("p2.stall_pop_count", st_count, 7);
    repeat (12) cyc();
    chk("p2.drained", st_count, 0);
    chk("p2.ovf_sticky", dr_ovf, 1);

    // Halt waits for the delay line and the queue to drain
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 64'h8000_1000 + 64'(4 * i));
      cyc();
    end
    in_valid = 1'b0; stop = 1'b1; out_ready = 1'b1;
    cyc();
    stop = 1'b0;
    chk("p4.halt_early", st_halt, 0);
    repeat (3) cyc();
    chk("p4.halt_pre", st_halt, 0);
    chk("p4.halt_pre_drop", dr_halt, 0);
    chk("p4.empty", st_count, 0);
    repeat (2) cyc();
    chk("p4.halt_set", st_halt, 1);
    chk("p4.halt_set_drop", dr_halt, 1);
    repeat (3) cyc();
    chk("p4.halt_held", st_halt, 1);

    // Reset in the middle of a drain
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 64'h8000_2000 + 64'(4 * i));
      cyc();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    cyc();
    chk("p5.count5", st_count, 5);
    resetn = 1'b0;
    #1;
    chk("p5.async_count", st_count, 0);
    chk("p5.async_valid", st_out_valid, 0);
    chk("p5.async_commit", st_commit, 0);
    chk("p5.async_drop_count", dr_count, 0);
    cyc();
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 64'h8000_3000 + 64'(4 * i));
      cyc();
    end
    in_valid = 1'b0;
    repeat (4) cyc();
    chk("p5.resume_commit", st_commit, 4);

    // Continuous push/pop so both pointers wrap twice
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 64'h8000_4000 + 64'(4 * i));
      cyc();
    end
    in_valid = 1'b0;
    repeat (3) cyc();
    chk("p6.commit_stall", st_commit, 16);
    chk("p6.commit_drop", dr_commit, 16);
    chk("p6.empty", st_count, 0);

    // Randomised traffic with occasional stop
    do_reset();
    for (int i = 0; i < 800; i++) begin
      drive(1'($urandom_range(0, 3) != 0), {$urandom, $urandom});
      out_ready = 1'($urandom_range(0, 2) == 0);
      stop = 1'($urandom_range(0, 299) == 0);
      cyc();
    end
    in_valid = 1'b0; stop = 1'b0; out_ready = 1'b1;
    repeat (12) cyc();
    chk("p7.drained", st_count, 0);
    chk("p7.drained_drop", dr_count, 0);

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
